// File: rtl/btn_event.sv
// Button event classifier: press/release edges, short, long and double click.
// Double-click support is compiled in when BTN_DCLICK_EN is defined.
module btn_event #(
    parameter int unsigned LONG_CYCLES   = 100000000,
    parameter int unsigned DCLICK_CYCLES = 30000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click
);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG_HELD,
        WAIT2,
        HELD2
    } state_t;

    localparam logic [26:0] CNT_MAX   = 27'h7FF_FFFF;
    localparam logic [26:0] LONG_LAST = 27'(LONG_CYCLES - 1);
    localparam logic [26:0] DCLK_LAST = 27'(DCLICK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic        btn_level_q, btn_level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        dclick_q, dclick_d;
    logic        press_edge, release_edge;

    assign press_edge   = btn_in & ~btn_level_q;
    assign release_edge = ~btn_in & btn_level_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 27'd1;
        btn_level_d = btn_in;
        press_d     = press_edge;
        release_d   = release_edge;
        short_d     = 1'b0;
        long_d      = 1'b0;
        dclick_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (press_edge) state_d = HELD;
            end
            HELD: begin
                // A release on the edge that would complete the hold wins.
                if (!btn_in) begin
`ifdef BTN_DCLICK_EN
                    state_d = WAIT2;
`else
                    state_d = IDLE;
                    short_d = 1'b1;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (!btn_in) state_d = IDLE;
            end
            WAIT2: begin
                if (cnt_q == DCLK_LAST) begin
                    short_d = 1'b1;
                    state_d = press_edge ? HELD : IDLE;
                end else if (press_edge) begin
`ifdef BTN_DCLICK_EN
                    dclick_d = 1'b1;
`endif
                    state_d  = HELD2;
                end
            end
            HELD2: begin
                if (!btn_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            dclick_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            dclick_q    <= dclick_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign double_click  = dclick_q;

endmodule

// File: tb/tb_btn_event.sv
// Testbench for btn_event: timestamp-based reference model plus directed scenarios.
// Honours BTN_DCLICK_EN the same way as the design.
module tb_btn_event;

    localparam int LONG   = 10;
    localparam int DCLICK = 5;
`ifdef BTN_DCLICK_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse;
    logic short_press, long_press, double_click;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    btn_event #(
        .LONG_CYCLES(LONG),
        .DCLICK_CYCLES(DCLICK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .short_press(short_press),
        .long_press(long_press),
        .double_click(double_click)
    );

    always #5 clk = ~clk;

    // Reference model: timestamps of the current press and pending short deadline.
    bit m_lvl = 0, m_in_press = 0, m_second = 0, m_long_done = 0;
    int m_press_t = 0;
    int m_short_due = -1;
    bit e_lvl = 0, e_press = 0, e_rel = 0, e_short = 0, e_long = 0, e_dbl = 0;

    task automatic model_step();
        bit b;
        b = btn_in;
        cyc++;
        e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_dbl = 0;
        if (rst) begin
            m_lvl = 0; m_in_press = 0; m_second = 0;
            m_long_done = 0; m_short_due = -1;
        end else begin
            e_press = b && !m_lvl;
            e_rel   = !b && m_lvl;
            if (e_rel) begin
                if (!m_second && !m_long_done) begin
                    if (DC) m_short_due = cyc + DCLICK;
                    else e_short = 1;
                end
                m_in_press = 0;
            end else if (m_in_press && !m_second && !m_long_done
                         && (cyc - m_press_t) == LONG) begin
                e_long = 1;
                m_long_done = 1;
            end
            if (e_press) begin
                if (m_short_due >= 0 && cyc < m_short_due) begin
                    e_dbl = 1;
                    m_second = 1;
                end else begin
                    if (m_short_due == cyc) e_short = 1;
                    m_second = 0;
                end
                m_short_due = -1;
                m_in_press = 1;
                m_press_t = cyc;
                m_long_done = 0;
            end else if (m_short_due == cyc) begin
                e_short = 1;
                m_short_due = -1;
            end
            m_lvl = b;
        end
        e_lvl = m_lvl;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // Event logs for directed scenarios (cycle numbers of observed pulses).
    int q_press[$], q_rel[$], q_short[$], q_long[$], q_dbl[$];

    initial forever begin
        @(negedge clk);
        chk_bit("btn_level", btn_level, e_lvl);
        chk_bit("press_pulse", press_pulse, e_press);
        chk_bit("release_pulse", release_pulse, e_rel);
        chk_bit("short_press", short_press, e_short);
        chk_bit("long_press", long_press, e_long);
        chk_bit("double_click", double_click, e_dbl);
        chk_bit("one_hot_class",
                (short_press + long_press + double_click) <= 2'd1, 1'b1);
        if (press_pulse === 1'b1) q_press.push_back(cyc);
        if (release_pulse === 1'b1) q_rel.push_back(cyc);
        if (short_press === 1'b1) q_short.push_back(cyc);
        if (long_press === 1'b1) q_long.push_back(cyc);
        if (double_click === 1'b1) q_dbl.push_back(cyc);
    end

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1000;
    endfunction

    task automatic clr();
        q_press.delete(); q_rel.delete(); q_short.delete();
        q_long.delete(); q_dbl.delete();
    endtask

    task automatic drive(input logic b, input int n);
        repeat (n) begin
            @(negedge clk);
            btn_in = b;
            rst = 1'b0;
        end
    endtask

    task automatic pulse_rst(input logic b);
        @(negedge clk);
        btn_in = b;
        rst = 1'b1;
    endtask

    initial begin
        int p0;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_level", btn_level, 1'b0);
        chk_int("reset_pulses",
                int'({press_pulse, release_pulse, short_press,
                      long_press, double_click}), 0);
        drive(0, 4);

        // Short press, no second press.
        clr();
        drive(1, 3);
        drive(0, 12);
        chk_int("s1_npress", q_press.size(), 1);
        p0 = qget(q_press, 0);
        chk_int("s1_rel", qget(q_rel, 0) - p0, 3);
        chk_int("s1_short", qget(q_short, 0) - p0, DC ? 8 : 3);
        chk_int("s1_nlong", q_long.size() + q_dbl.size(), 0);

        // Long hold of 20 cycles.
        clr();
        drive(1, 20);
        drive(0, 12);
        p0 = qget(q_press, 0);
        chk_int("s2_long_at", qget(q_long, 0) - p0, 10);
        chk_int("s2_nlong", q_long.size(), 1);
        chk_int("s2_nshort", q_short.size(), 0);
        chk_int("s2_rel", qget(q_rel, 0) - p0, 20);

        // Press 3, release 2, press 3.
        clr();
        drive(1, 3);
        drive(0, 2);
        drive(1, 3);
        drive(0, 12);
        chk_int("s3_npress", q_press.size(), 2);
        chk_int("s3_ndbl", q_dbl.size(), DC ? 1 : 0);
        if (DC) chk_int("s3_dbl_at", qget(q_dbl, 0), qget(q_press, 1));
        chk_int("s3_nshort", q_short.size(), DC ? 0 : 2);
        chk_int("s3_nlong", q_long.size(), 0);

        // New press exactly DCLICK cycles after release.
        clr();
        drive(1, 3);
        drive(0, 5);
        drive(1, 3);
        drive(0, 12);
        chk_int("s4_nshort", q_short.size(), 2);
        chk_int("s4_short0", qget(q_short, 0),
                DC ? qget(q_press, 1) : qget(q_rel, 0));
        chk_int("s4_short1", qget(q_short, 1) - qget(q_press, 1), DC ? 8 : 3);
        chk_int("s4_ndbl", q_dbl.size(), 0);

        // Reset mid-hold at k+6.
        clr();
        drive(1, 6);
        pulse_rst(1);
        @(posedge clk);
        #1;
        chk_int("s5_rst_outs",
                int'({btn_level, press_pulse, release_pulse, short_press,
                      long_press, double_click}), 0);
        drive(1, 3);
        drive(0, 12);
        chk_int("s5_npress", q_press.size(), 2);
        chk_int("s5_repress", qget(q_press, 1) - qget(q_press, 0), 7);
        chk_int("s5_nlong", q_long.size(), 0);
        chk_int("s5_nshort", q_short.size(), 1);

        // Release on the edge completing LONG held cycles.
        clr();
        drive(1, 10);
        drive(0, 12);
        chk_int("s6_nlong", q_long.size(), 0);
        chk_int("s6_rel", qget(q_rel, 0) - qget(q_press, 0), 10);
        chk_int("s6_nshort", q_short.size(), 1);

        // Randomized runs with occasional resets, checked by the model.
        for (int i = 0; i < 400; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) pulse_rst(b);
            drive(b, $urandom_range(1, 14));
        end
        drive(0, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
